// File: rtl/video_scanout.sv
// video_scanout: fixed-timing raster generator that scans a 1-bit-per-pixel
// bitmap out of an 8-bit video RAM with vertical scroll and polarity invert.
// All video outputs are registered and share one clock of latency relative
// to the raster counters.
module video_scanout #(
   parameter int H_ACTIVE = 128,
   parameter int H_FP     = 8,
   parameter int H_SYNC   = 16,
   parameter int H_BP     = 8,
   parameter int V_ACTIVE = 128,
   parameter int V_FP     = 2,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  scroll,
   input  logic        invert,
   output logic [10:0] vram_addr,
   input  logic [7:0]  vram_q,
   output logic        pix,
   output logic        de,
   output logic        hsync_n,
   output logic        vsync_n,
   output logic        frame_irq
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   // Counters are at least 8 bits so the 7-bit line field can always be sliced.
   localparam int HW = ($clog2(H_TOTAL) > 8) ? $clog2(H_TOTAL) : 8;
   localparam int VW = ($clog2(V_TOTAL) > 8) ? $clog2(V_TOTAL) : 8;

   localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_PRE       = HW'(H_TOTAL - 2);
   localparam logic [HW-1:0] H_VIS       = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_FETCH_END = HW'(H_ACTIVE - 2);
   localparam logic [HW-1:0] HS_START    = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END      = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_VIS       = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_START    = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END      = VW'(V_ACTIVE + V_FP + V_SYNC);

   logic [HW-1:0] h_cnt_r;
   logic [VW-1:0] v_cnt_r;
   logic [6:0]    scroll_lat_r;
   logic [7:0]    shreg_r;

   logic          h_last_s;
   logic          v_last_s;
   logic          visible_s;
   logic [VW-1:0] v_next_s;
   logic [6:0]    line_s;
   logic [6:0]    next_line_s;
   logic [3:0]    byte_next_s;
   logic          group_fetch_s;
   logic          prefetch_s;

   // Raster decode and fetch-address selection.
   always_comb begin
      h_last_s    = (h_cnt_r == H_LAST);
      v_last_s    = (v_cnt_r == V_LAST);
      visible_s   = (h_cnt_r < H_VIS) && (v_cnt_r < V_VIS);
      line_s      = 7'(v_cnt_r) + scroll_lat_r;
      byte_next_s = 4'((h_cnt_r + HW'(2)) >> 3);
      // The line-0 prefetch happens one clock before scroll is latched,
      // so it uses the value about to be captured.
      if (v_last_s) begin
         v_next_s    = {VW{1'b0}};
         next_line_s = scroll;
      end else begin
         v_next_s    = v_cnt_r + VW'(1);
         next_line_s = 7'(v_cnt_r + VW'(1)) + scroll_lat_r;
      end
      // Group k is requested at h = 8k-2 so the RAM data lands at h = 8k.
      group_fetch_s = (h_cnt_r[2:0] == 3'd6) && (h_cnt_r < H_FETCH_END) && (v_cnt_r < V_VIS);
      prefetch_s    = (h_cnt_r == H_PRE) && (v_next_s < V_VIS);
   end

   // Horizontal and vertical raster counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt_r <= {HW{1'b0}};
         v_cnt_r <= {VW{1'b0}};
      end else if (h_last_s) begin
         h_cnt_r <= {HW{1'b0}};
         v_cnt_r <= v_next_s;
      end else begin
         h_cnt_r <= h_cnt_r + HW'(1);
      end
   end

   // Scroll offset is captured once per frame, at the very last pixel clock.
   always_ff @(posedge clk) begin
      if (rst) begin
         scroll_lat_r <= 7'd0;
      end else if (h_last_s && v_last_s) begin
         scroll_lat_r <= scroll;
      end else begin
         scroll_lat_r <= scroll_lat_r;
      end
   end

   // VRAM address: line-start prefetch plus in-line group fetches only.
   always_ff @(posedge clk) begin
      if (rst) begin
         vram_addr <= 11'd0;
      end else if (prefetch_s) begin
         vram_addr <= {next_line_s, 4'd0};
      end else if (group_fetch_s) begin
         vram_addr <= {line_s, byte_next_s};
      end else begin
         vram_addr <= vram_addr;
      end
   end

   // Pixel shifter: the leftmost pixel goes straight from the RAM data to pix
   // while the remaining seven bits are queued in the shift register.
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg_r <= 8'd0;
         pix     <= 1'b0;
      end else if (visible_s) begin
         if (h_cnt_r[2:0] == 3'd0) begin
            pix     <= vram_q[7] ^ invert;
            shreg_r <= {vram_q[6:0], 1'b0};
         end else begin
            pix     <= shreg_r[7] ^ invert;
            shreg_r <= {shreg_r[6:0], 1'b0};
         end
      end else begin
         pix     <= 1'b0;
         shreg_r <= shreg_r;
      end
   end

   // Timing outputs, aligned with pix.
   always_ff @(posedge clk) begin
      if (rst) begin
         de        <= 1'b0;
         hsync_n   <= 1'b1;
         vsync_n   <= 1'b1;
         frame_irq <= 1'b0;
      end else begin
         de        <= visible_s;
         hsync_n   <= !((h_cnt_r >= HS_START) && (h_cnt_r < HS_END));
         vsync_n   <= !((v_cnt_r >= VS_START) && (v_cnt_r < VS_END));
         frame_irq <= (h_cnt_r == {HW{1'b0}}) && (v_cnt_r == V_VIS);
      end
   end

endmodule

// File: tb/tb_video_scanout.sv
// tb_video_scanout: randomized bench with a frame-arithmetic reference model
// feeding an expected-value queue that an independent monitor drains.
module tb_video_scanout;

   localparam int H_ACTIVE = 128;
   localparam int H_FP     = 8;
   localparam int H_SYNC   = 16;
   localparam int H_TOTAL  = 160;
   localparam int V_ACTIVE = 128;
   localparam int V_FP     = 2;
   localparam int V_SYNC   = 2;
   localparam int V_TOTAL  = 136;
   localparam int FRAME    = H_TOTAL * V_TOTAL;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  scroll;
   logic        invert;
   logic [10:0] vram_addr;
   logic [7:0]  vram_q;
   logic        pix, de, hsync_n, vsync_n, frame_irq;

   logic [7:0]  mem [0:2047];

   typedef struct packed {
      logic        pix;
      logic        de;
      logic        hs;
      logic        vs;
      logic        irq;
      logic        addr_chk;
      logic [10:0] addr;
   } exp_t;

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   fail_prints = 0;
   int   t  = 0;   // pixel clocks since reset release
   int   sl = 0;   // scroll offset in force for the current frame

   video_scanout dut (
      .clk       (clk),
      .rst       (rst),
      .scroll    (scroll),
      .invert    (invert),
      .vram_addr (vram_addr),
      .vram_q    (vram_q),
      .pix       (pix),
      .de        (de),
      .hsync_n   (hsync_n),
      .vsync_n   (vsync_n),
      .frame_irq (frame_irq)
   );

   always #5 clk = ~clk;

   // Synchronous-read video RAM.
   always @(posedge clk) vram_q <= mem[vram_addr];

   // Expected outputs for the cycle after the current one.
   task automatic model_step();
      exp_t e;
      int h, v, h2, v2, vn, line;
      logic [7:0] b;
      e = '0;
      if (rst) begin
         e.hs = 1'b1; e.vs = 1'b1; e.addr_chk = 1'b1; e.addr = 11'd0;
         t = 0; sl = 0;
      end else begin
         h = t % H_TOTAL;
         v = (t / H_TOTAL) % V_TOTAL;
         if (h < H_ACTIVE && v < V_ACTIVE) begin
            line  = (v + sl) % 128;
            b     = mem[line * 16 + h / 8];
            e.de  = 1'b1;
            e.pix = b[7 - (h % 8)] ^ invert;
         end
         e.hs  = !(h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC);
         e.vs  = !(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC);
         e.irq = (h == 0 && v == V_ACTIVE);
         if (h == H_TOTAL - 1 && v == V_TOTAL - 1) sl = scroll;
         t  = t + 1;
         h2 = t % H_TOTAL;
         v2 = (t / H_TOTAL) % V_TOTAL;
         if (h2 % 8 == 7 && h2 < H_ACTIVE - 1 && v2 < V_ACTIVE) begin
            e.addr_chk = 1'b1;
            e.addr     = 11'((((v2 + sl) % 128) * 16) + (h2 + 1) / 8);
         end else if (h2 == H_TOTAL - 1) begin
            vn = (v2 + 1) % V_TOTAL;
            if (vn < V_ACTIVE) begin
               e.addr_chk = 1'b1;
               e.addr     = 11'(((vn == 0) ? int'(scroll) : (vn + sl) % 128) * 16);
            end
         end
      end
      exp_q.push_back(e);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst = 1'b0;
         if ($urandom_range(0, 63) == 0) invert = ~invert;
         model_step();
      end
   endtask

   // Monitor: compare every presented output cycle against the queue head.
   initial begin
      exp_t e;
      logic bad;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            bad = 1'b0;
            vectors++;
            if ({pix, de, hsync_n, vsync_n, frame_irq} !== {e.pix, e.de, e.hs, e.vs, e.irq}) begin
               bad = 1'b1;
               if (fail_prints < 20)
                  $display("FAIL video_out at %0t: pix/de/hs/vs/irq got %b%b%b%b%b expected %b%b%b%b%b",
                           $time, pix, de, hsync_n, vsync_n, frame_irq, e.pix, e.de, e.hs, e.vs, e.irq);
               fail_prints++;
            end
            if (e.addr_chk && vram_addr !== e.addr) begin
               bad = 1'b1;
               if (fail_prints < 20)
                  $display("FAIL vram_addr at %0t: got 0x%03h expected 0x%03h", $time, vram_addr, e.addr);
               fail_prints++;
            end
            if (bad) miscompares++;
         end
      end
   end

   // Stimulus.
   initial begin
      int guard;
      rst = 1'b1; scroll = 7'd0; invert = 1'b0;
      for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
      mem[0] = 8'hFC;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         model_step();
      end
      // First frame with scroll 0; scroll change mid-frame applies next frame.
      run(10000);
      scroll = 7'd5;
      run(35000);
      // Walk to line 60, pixel 70 and reset there.
      guard = 0;
      while ((t % FRAME) != 60 * H_TOTAL + 70 && guard < FRAME + 10) begin
         run(1);
         guard++;
      end
      if (guard >= FRAME + 10) begin
         $display("FAIL reset_point: not reached after %0d cycles, required < %0d", guard, FRAME + 10);
         miscompares++;
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         rst = 1'b1;
         if (i == 0) begin
            for (int a = 0; a < 1024; a++) mem[a] = 8'd0;
            scroll = 7'($urandom_range(0, 127));
         end
         model_step();
      end
      run(23000);
      @(posedge clk);
      #4;
      if (exp_q.size() != 0) begin
         $display("FAIL queue_drain: %0d entries left, required 0", exp_q.size());
         miscompares++;
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/video_scanout.md
VIDEO_SCANOUT -- requirements
Module: video_scanout

Interface
REQ-001 Parameter H_ACTIVE, 128, visible pixels per line (multiple of 8; 128 fills the 2 KB bitmap exactly).
REQ-002 Parameter H_FP, 8, horizontal front porch in clocks.
REQ-003 Parameter H_SYNC, 16, horizontal sync width in clocks.
REQ-004 Parameter H_BP, 8, horizontal back porch in clocks; H_TOTAL = sum of the four (default 160).
REQ-005 Parameter V_ACTIVE, 128, visible lines.
REQ-006 Parameter V_FP, 2, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 2, vertical sync width in lines.
REQ-008 Parameter V_BP, 4, vertical back porch in lines; V_TOTAL default 136.
REQ-009 clk  in  1  single clock, one pixel per cycle; reset is synchronous and active-high.
REQ-010 rst  in  1  synchronous, active-high reset.
REQ-011 scroll  in  7  vertical scroll offset in lines.
REQ-012 invert  in  1  1 = invert visible pixel polarity.
REQ-013 vram_addr  out  11  byte address to the video RAM 8-bit read port ({line[6:0], byte[3:0]}).
REQ-014 vram_q  in  8  read data; valid the cycle after vram_addr is sampled (1-cycle synchronous read, no output register).
REQ-015 pix  out  1  pixel value.
REQ-016 de  out  1  display enable, high during visible pixels.
REQ-017 hsync_n  out  1  horizontal sync, active low.
REQ-018 vsync_n  out  1  vertical sync, active low.
REQ-019 frame_irq  out  1  one-cycle pulse at start of vertical blanking.

Function
REQ-020 h_cnt counts 0..H_TOTAL-1 and wraps to 0; v_cnt increments when h_cnt wraps and counts 0..V_TOTAL-1, wrapping to 0.
REQ-021 Visible region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-022 hsync active for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync active for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
REQ-023 pix, de, hsync_n and vsync_n are registered and reflect the counter state of the previous cycle, all with identical 1-cycle latency.
REQ-024 Source line = (v_cnt + scroll_lat) mod 128, 7-bit wrap-around; byte index = h_cnt/8.
REQ-025 vram_addr holds the address of group k (pixels 8k..8k+7) during the cycle with h_cnt = 8k-1; for k=0, during h_cnt = H_TOTAL-1 of the preceding line (line 0 of the next frame after the last line).
REQ-026 At h_cnt = 8k in the visible region, vram_q is loaded into an 8-bit shift register; bit 7 is the leftmost pixel and is emitted first.
REQ-027 pix = (shift bit XOR invert) when visible, else 0 regardless of invert.
REQ-028 scroll is latched into scroll_lat at h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1 only; changes mid-frame take effect from the next frame.
REQ-029 frame_irq is high for exactly one cycle, the cycle after h_cnt = 0 and v_cnt = V_ACTIVE, registered like the other outputs.
REQ-030 vram_addr is not driven to new values during blanking except for the line-start prefetch of REQ-025.

Reset
REQ-031 While rst is high: h_cnt = 0, v_cnt = 0, scroll_lat = 0, vram_addr = 0, shift register = 0, pix = 0, de = 0, hsync_n = 1, vsync_n = 1, frame_irq = 0.
REQ-032 rst takes effect at the next clk edge, including mid-line and mid-frame; no partial line or irq pulse follows it.
REQ-033 On the first cycle after rst deasserts, h_cnt = 0 and v_cnt = 0; vram_q = mem[0] in that cycle because vram_addr = 0 held during reset, so the first frame is complete.

Verification
REQ-034 Reset release with mem[0] = 0xFC and invert = 0 -> pix sequence 1,1,1,1,1,1,0,0 on cycles 1..8 with de = 1, then mem[1] bits follow.
REQ-035 Free run -> hsync_n low for 16 cycles starting 1 cycle after h_cnt = 136; period 160; vsync_n low for lines 130..131; frame period 21760 cycles.
REQ-036 Free run -> frame_irq is a single-cycle pulse once per 21760 cycles, coincident with the first blank line; de = 0 and pix = 0 throughout blanking, even with invert = 1.
REQ-037 scroll = 5 applied mid-frame -> current frame unchanged; next frame line 0 fetches addresses 0x050..0x05F; line 123 wraps to addresses 0x000..0x00F.
REQ-038 invert toggled with an all-zero bitmap -> pix = 1 only where de = 1.
REQ-039 rst asserted at v_cnt = 60, h_cnt = 70 for 3 cycles -> outputs match REQ-031 values; frame restarts at line 0 with no frame_irq pulse.
